fp_add_controller: RTL and testbench
====================================

// Module: fp_add_controller
// PURPOSE
//  Multicycle FSM that sequences the single-precision FP add/sub datapath: loads A then B from the shared
//  data_in bus, resolves effective operation and result sign, steers align/add/normalize, and writes the
//  result register. It sits between the host handshake (start/op/done) and the datapath control pins.
// PARAMETERS
//  BACK_TO_BACK  1  1: start is accepted in DONE as well as IDLE; 0: start is accepted in IDLE only
// PORTS
//  clk               in   1  system clock, all state on rising edge
//  rst               in   1  synchronous, active-high reset
//  start             in   1  request one operation; sampled only when accepting (IDLE, or DONE if BACK_TO_BACK)
//  op                in   1  0 = A+B, 1 = A-B; captured with start
//  sign_a, sign_b    in   1  operand sign bits from datapath
//  a_gt_eq_b         in   1  |A| >= |B| from datapath comparator
//  spl_case          in   1  NaN/Inf/zero special case detected
//  alu_carry         in   1  mantissa add carry-out
//  eqz               in   1  ALU result is all zero
//  lzc_flag          in   1  leading-zero count nonzero
//  load_a, load_b    out  1  operand register write enables; data_in must hold A / B in that cycle
//  add_sub           out  1  0 = mantissa add, 1 = mantissa subtract (effective op)
//  sel_larger        out  1  1 = A is the larger operand
//  sel_result        out  1  1 = select special-case result, 0 = computed result
//  load_result       out  1  result register write enable
//  flush_exp         out  1  clear exponent register (exact cancellation)
//  normalize_enable  out  1  apply exponent adjust + mantissa shift
//  normalize_mode    out  1  1 = right shift 1 / exp+1 (carry), 0 = left shift lzc / exp-lzc
//  op_sign           out  1  result sign bit
//  busy              out  1  high in every state except IDLE
//  done              out  1  one-cycle pulse; data_out is valid from this cycle until the next load_result
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; captured op/sign/compare registers 0. rst wins over start in the same cycle.
//  - rst asserted mid-operation: IDLE next cycle, all control pins 0; partial result never written, no done.
//  - States/outputs (Moore, decoded from state plus captured flags):
//    IDLE  : start -> LOAD_A (op captured)
//    LOAD_A: load_a=1 -> LOAD_B
//    LOAD_B: load_b=1 -> CMP
//    CMP   : capture gte=a_gt_eq_b, sa, sb, spl=spl_case; spl -> WRITE else -> ALIGN
//    ALIGN : sel_larger=gte, add_sub=eff; exponent register loads exp_larger (normalize_enable=0) -> NORM
//    NORM  : alu_carry -> normalize_enable=1, mode=1; else eqz -> flush_exp=1; else lzc_flag -> normalize_enable=1,
//            mode=0; else all 0 -> WRITE
//    WRITE : load_result=1, sel_result=spl, sel_larger/add_sub held -> DONE
//    DONE  : done=1; start (BACK_TO_BACK=1) -> LOAD_A, else -> IDLE
//  - eff = op ^ sa ^ sb. op_sign = gte ? sa : (sb ^ op); forced 0 when eqz in NORM/WRITE (exact cancel -> +0).
//  - sel_larger and add_sub are held constant from ALIGN through WRITE, so datapath combinational paths stay stable.
//  - Latency: start in cycle 0 -> load_a in cycle 1, load_b in cycle 2, load_result in cycle 6 (normal)
//    or cycle 4 (special), done one cycle after load_result. Back-to-back throughput: one op per 7 cycles.
//  - start outside an accepting state is ignored (not queued). op and start changes after capture have no effect.
//  - Status inputs are sampled only in the states listed; X on them elsewhere has no effect.
//  - Illegal state encoding -> IDLE next cycle.
// STRUCTURE
//  - Shared header fp_add_defs.vh: state codes (IDLE..DONE, 3-bit), OP_ADD=0/OP_SUB=1, NORM_RIGHT=1/NORM_LEFT=0.
//  - Single module; sign/effective-op logic is a few gates and stays inline, so no sub-module.
//  - Top-level fp_adder instantiates fp_add_controller and datapath, wiring the status and control pins 1:1.
// TESTING (integrated with datapath)
//  - 0x3F800000 + 0x40000000 (1+2): no carry, lzc=0 -> no normalize, data_out=0x40400000, done at cycle 7.
//  - 0x3FC00000 + 0x3FC00000 (1.5+1.5): alu_carry=1 -> normalize_mode=1 in NORM, data_out=0x40400000.
//  - 0x40400000 - 0x40400000 (3-3): eqz -> flush_exp=1, op_sign=0, data_out=0x00000000.
//  - 0x7F800000 + 0x3F800000 (Inf+1): spl_case -> sel_result=1, load_result at cycle 4, data_out=0x7F800000.
//  - 0x3F800000 - 0x40000000 (1-2): gte=0, eff=1, op_sign=1, left normalize, data_out=0xBF800000.
//  - rst high during NORM: next cycle IDLE, busy=0, no load_result/done; start held in DONE with BACK_TO_BACK=1:
//    load_a on the next cycle.

Source files
------------

// File: rtl/fp_add_controller_pkg.sv
// Shared types and constants for the FP add/sub sequencing controller.
package fp_add_controller_pkg;

  localparam int unsigned STATE_W = 3;

  // One code per step of the add/sub sequence; all eight encodings are used.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CMP    = 3'd3,
    ST_ALIGN  = 3'd4,
    ST_NORM   = 3'd5,
    ST_WRITE  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  localparam logic OP_ADD     = 1'b0;
  localparam logic OP_SUB     = 1'b1;
  localparam logic NORM_RIGHT = 1'b1;
  localparam logic NORM_LEFT  = 1'b0;

  // Datapath status captured during the operation.
  typedef struct packed {
    logic gte;   // |A| >= |B|
    logic sa;    // sign of A
    logic sb;    // sign of B
    logic spl;   // special-case operand (NaN/Inf/zero)
    logic zero;  // exact cancellation seen in NORM
  } flags_t;

  // Sign of the larger-magnitude operand, with B's sign flipped for subtraction.
  function automatic logic result_sign(input flags_t f, input logic op);
    return f.gte ? f.sa : (f.sb ^ op);
  endfunction

endpackage

// File: rtl/fp_add_controller.sv
// Multicycle sequencer for the single-precision FP add/sub datapath.
// Loads A then B from the shared bus, captures compare/sign/special status,
// steers align, add, normalize and result write, then pulses done.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, op                  host request and operation (0 add, 1 sub)
//   sign_a, sign_b, a_gt_eq_b,
//   spl_case, alu_carry, eqz,
//   lzc_flag                   datapath status inputs
//   load_a, load_b, add_sub, sel_larger, sel_result, load_result,
//   flush_exp, normalize_enable, normalize_mode, op_sign
//                              datapath control outputs
//   busy, done                 host status
// Control outputs are Moore-decoded from the state register and captured
// flags; NORM additionally decodes the live normalize status of that cycle.
module fp_add_controller
  import fp_add_controller_pkg::*;
#(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  input  logic sign_a,
  input  logic sign_b,
  input  logic a_gt_eq_b,
  input  logic spl_case,
  input  logic alu_carry,
  input  logic eqz,
  input  logic lzc_flag,
  output logic load_a,
  output logic load_b,
  output logic add_sub,
  output logic sel_larger,
  output logic sel_result,
  output logic load_result,
  output logic flush_exp,
  output logic normalize_enable,
  output logic normalize_mode,
  output logic op_sign,
  output logic busy,
  output logic done
);

  state_e state_q, state_d;
  flags_t flags_q, flags_d;
  logic   op_q, op_d;
  logic   eff_op;
  logic   sign_raw;

  assign eff_op   = op_q ^ flags_q.sa ^ flags_q.sb;
  assign sign_raw = result_sign(flags_q, op_q);

  // State and captured-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flags_q <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      op_q    <= op_d;
    end
  end

  // Next state, flag capture and control decode.
  always_comb begin
    state_d          = state_q;
    flags_d          = flags_q;
    op_d             = op_q;
    load_a           = 1'b0;
    load_b           = 1'b0;
    add_sub          = 1'b0;
    sel_larger       = 1'b0;
    sel_result       = 1'b0;
    load_result      = 1'b0;
    flush_exp        = 1'b0;
    normalize_enable = 1'b0;
    normalize_mode   = NORM_LEFT;
    op_sign          = sign_raw & ~flags_q.zero;
    busy             = (state_q != ST_IDLE);
    done             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          op_d    = op;
          flags_d = '0;
        end
      end
      ST_LOAD_A: begin
        load_a  = 1'b1;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        load_b  = 1'b1;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        flags_d.gte = a_gt_eq_b;
        flags_d.sa  = sign_a;
        flags_d.sb  = sign_b;
        flags_d.spl = spl_case;
        state_d     = spl_case ? ST_WRITE : ST_ALIGN;
      end
      ST_ALIGN: begin
        sel_larger = flags_q.gte;
        add_sub    = eff_op;
        state_d    = ST_NORM;
      end
      ST_NORM: begin
        sel_larger = flags_q.gte;
        add_sub    = eff_op;
        // Carry takes priority over cancellation, which beats left shift.
        if (alu_carry) begin
          normalize_enable = 1'b1;
          normalize_mode   = NORM_RIGHT;
        end else if (eqz) begin
          flush_exp = 1'b1;
        end else if (lzc_flag) begin
          normalize_enable = 1'b1;
          normalize_mode   = NORM_LEFT;
        end
        // Exact cancellation yields +0; remember it for the WRITE cycle.
        flags_d.zero = eqz;
        op_sign      = sign_raw & ~eqz;
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        sel_larger  = flags_q.gte;
        add_sub     = eff_op;
        sel_result  = flags_q.spl;
        load_result = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (BACK_TO_BACK && start) begin
          state_d = ST_LOAD_A;
          op_d    = op;
          flags_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_add_controller.sv
module tb_fp_add_controller;
  import fp_add_controller_pkg::*;

  logic clk = 1'b0;
  logic rst, start, op, sign_a, sign_b, a_gt_eq_b, spl_case, alu_carry, eqz, lzc_flag;
  logic load_a, load_b, add_sub, sel_larger, sel_result, load_result;
  logic flush_exp, normalize_enable, normalize_mode, op_sign, busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   lat;
    logic sel_result;
    logic op_sign;
    logic add_sub;
    logic sel_larger;
    logic norm_en;
    logic norm_mode;
    logic flush;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fp_add_controller #(.BACK_TO_BACK(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .sign_a(sign_a), .sign_b(sign_b), .a_gt_eq_b(a_gt_eq_b), .spl_case(spl_case),
    .alu_carry(alu_carry), .eqz(eqz), .lzc_flag(lzc_flag),
    .load_a(load_a), .load_b(load_b), .add_sub(add_sub), .sel_larger(sel_larger),
    .sel_result(sel_result), .load_result(load_result), .flush_exp(flush_exp),
    .normalize_enable(normalize_enable), .normalize_mode(normalize_mode),
    .op_sign(op_sign), .busy(busy), .done(done)
  );

  task automatic test_reset();
    logic [11:0] outs;
    rst = 1'b1; start = 1'b1; op = OP_SUB;
    sign_a = 1'b1; sign_b = 1'b1; a_gt_eq_b = 1'b1; spl_case = 1'b0;
    alu_carry = 1'b0; eqz = 1'b0; lzc_flag = 1'b0;
    repeat (2) @(negedge clk);
    outs = {load_a, load_b, add_sub, sel_larger, sel_result, load_result,
            flush_exp, normalize_enable, normalize_mode, op_sign, busy, done};
    tests++;
    if (outs !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 000", outs);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_after_release: busy got %b expected 0", busy);
    end
  endtask

  // Drives one full operation and checks its sequence against the scoreboard.
  task automatic run_op(input logic o, input logic sa, input logic sb, input logic gte,
                        input logic spl, input logic cy, input logic ez, input logic lz);
    exp_t e;
    exp_t g;
    bit   seen_done;
    e.lat        = spl ? 4 : 6;
    e.sel_result = spl;
    e.add_sub    = o ^ sa ^ sb;
    e.sel_larger = gte;
    e.op_sign    = (!spl && ez) ? 1'b0 : (gte ? sa : (sb ^ o));
    e.norm_en    = !spl && (cy || (!ez && lz));
    e.norm_mode  = !spl && cy;
    e.flush      = !spl && !cy && ez;
    sb_q.push_back(e);

    start = 1'b1; op = o; sign_a = sa; sign_b = sb; a_gt_eq_b = gte;
    spl_case = spl; alu_carry = cy; eqz = ez; lzc_flag = lz;
    seen_done = 1'b0;
    for (int c = 1; c <= 12 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if ({load_a, load_b, busy} !== 3'b101) begin
          fails++;
          $display("FAIL load_a_cycle: {load_a,load_b,busy} got %b expected 101", {load_a, load_b, busy});
        end
      end
      if (c == 2) begin
        tests++;
        if ({load_a, load_b} !== 2'b01) begin
          fails++;
          $display("FAIL load_b_cycle: {load_a,load_b} got %b expected 01", {load_a, load_b});
        end
      end
      if (c == 5 && !spl && sb_q.size() > 0) begin
        tests++;
        if ({normalize_enable, normalize_mode, flush_exp, op_sign} !==
            {sb_q[0].norm_en, sb_q[0].norm_mode, sb_q[0].flush, sb_q[0].op_sign}) begin
          fails++;
          $display("FAIL norm_controls: {en,mode,flush,sign} got %b%b%b%b expected %b%b%b%b",
                   normalize_enable, normalize_mode, flush_exp, op_sign,
                   sb_q[0].norm_en, sb_q[0].norm_mode, sb_q[0].flush, sb_q[0].op_sign);
        end
      end
      if (load_result === 1'b1) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_load_result: got load_result at cycle %0d expected none", c);
        end else begin
          g = sb_q.pop_front();
          if (c != g.lat || sel_result !== g.sel_result || op_sign !== g.op_sign ||
              add_sub !== g.add_sub || sel_larger !== g.sel_larger) begin
            fails++;
            $display("FAIL write_result: cyc/selr/sign/addsub/larger got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                     c, sel_result, op_sign, add_sub, sel_larger,
                     g.lat, g.sel_result, g.op_sign, g.add_sub, g.sel_larger);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        tests++;
        if (c != e.lat + 1) begin
          fails++;
          $display("FAIL done_latency: got cycle %0d expected %0d", c, e.lat + 1);
        end
      end
      if (c == 1) begin
        start = 1'b0;
        op    = ~o;
      end
      // Captured status must no longer matter once CMP has passed.
      if (c == 4) begin
        sign_a = ~sa; sign_b = ~sb; a_gt_eq_b = ~gte; spl_case = ~spl;
      end
    end
    if (!seen_done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within 12 cycles expected done");
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_done: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 1+2
    run_op(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // 1.5+1.5
    run_op(OP_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // 3-3
    run_op(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // Inf+1
    run_op(OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 1-2
    run_op(OP_SUB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // (-3)-(-3) -> +0
    run_op(OP_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // (-4)+1
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom);
      run_op(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit bad;
    start = 1'b1; op = OP_ADD; sign_a = 1'b0; sign_b = 1'b0; a_gt_eq_b = 1'b1;
    spl_case = 1'b0; alu_carry = 1'b1; eqz = 1'b0; lzc_flag = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (normalize_enable !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_in_norm: normalize_enable got %b expected 1", normalize_enable);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, load_result, done, normalize_enable, sel_larger} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset_idle: {busy,load_result,done,norm,larger} got %b expected 00000",
               {busy, load_result, done, normalize_enable, sel_larger});
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (load_result !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL mid_reset_no_write: got activity after reset expected none");
    end
  endtask

  task automatic test_back_to_back();
    bit got_done;
    start = 1'b1; op = OP_ADD; sign_a = 1'b0; sign_b = 1'b0; a_gt_eq_b = 1'b1;
    spl_case = 1'b0; alu_carry = 1'b0; eqz = 1'b0; lzc_flag = 1'b0;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 2; c <= 12 && !got_done; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b1;   // ignored while busy
      if (c == 5) start = 1'b0;
      if (done === 1'b1) got_done = 1'b1;
    end
    tests++;
    if (!got_done) begin
      fails++;
      $display("FAIL b2b_first_done: got no done expected done");
    end
    start = 1'b1; op = OP_SUB;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({load_a, busy} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_load_a: {load_a,busy} got %b expected 11", {load_a, busy});
    end
    got_done = 1'b0;
    for (int c = 2; c <= 12 && !got_done; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        tests++;
        if (c != 7) begin
          fails++;
          $display("FAIL b2b_second_latency: done got cycle %0d expected 7", c);
        end
      end
    end
    if (!got_done) begin
      tests++;
      fails++;
      $display("FAIL b2b_second_done: got no done expected done");
    end
    @(negedge clk);
    tests++;
    if ({busy, load_a} !== 2'b00) begin
      fails++;
      $display("FAIL start_not_queued: {busy,load_a} got %b expected 00", {busy, load_a});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_op();
    test_back_to_back();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
